// File: rtl/elgamal_sequencer.sv
// ElGamal keygen/encrypt/decrypt sequencer around one shared square-and-multiply engine.
// Optional macro ELGAMAL_SEQ_EARLY_EXIT_EN ends each EXP phase once the exponent is exhausted.
module elgamal_sequencer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] g,
  input  logic [W-1:0] q,
  input  logic [W-1:0] priv_a,
  input  logic [W-1:0] eph_k,
  input  logic [W-1:0] pub_y,
  input  logic [W-1:0] msg,
  input  logic [W-1:0] c1_in,
  input  logic [W-1:0] c2_in,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] res0,
  output logic [W-1:0] res1
);
  // state | meaning
  // IDLE  | waiting for start, ready high
  // EXP   | one square-and-multiply step per cycle
  // MUL   | single modular product closing ENCRYPT/DECRYPT
  // DONE  | done pulse, results/err valid
  typedef enum logic [1:0] {IDLE, EXP, MUL, DONE} state_t;

  localparam logic [1:0] OP_KEYGEN  = 2'd0;
  localparam logic [1:0] OP_ENCRYPT = 2'd1;
  localparam logic [1:0] OP_DECRYPT = 2'd2;
  localparam logic [1:0] OP_RSVD    = 2'd3;

  state_t       state;
  logic [1:0]   op_r;
  logic         phase;
  logic [W-1:0] q_r, k_r, y_r, m_r, c2_r;
  logic [W-1:0] acc, base, shreg, hold;

  logic [2*W-1:0] prod_ab, prod_bb;
  logic [W-1:0]   mod_ab, mod_bb, step_acc, g_mod, init_base;
  logic           illegal, exp_last;

  assign prod_ab  = {{W{1'b0}}, acc}  * {{W{1'b0}}, base};
  assign prod_bb  = {{W{1'b0}}, base} * {{W{1'b0}}, base};
  assign mod_ab   = W'(prod_ab % {{W{1'b0}}, q_r});
  assign mod_bb   = W'(prod_bb % {{W{1'b0}}, q_r});
  assign step_acc = shreg[0] ? mod_ab : acc;

  // Operand checks on the raw inputs in the accept cycle; q < 2 short-circuits the mod.
  assign g_mod     = (q < W'(2)) ? '0 : g % q;
  assign init_base = (q < W'(2)) ? '0 : ((op == OP_DECRYPT) ? c1_in : g) % q;
  assign illegal   = (op == OP_RSVD) || (q < W'(2)) ||
                     ((op != OP_DECRYPT) && (g_mod == '0));

`ifdef ELGAMAL_SEQ_EARLY_EXIT_EN
  assign exp_last = ((shreg >> 1) == '0);
`else
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);
  logic [CW-1:0] cnt;

  assign exp_last = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if ((state == IDLE) || (state == EXP && exp_last))
      cnt <= CNT_INIT;
    else if (state == EXP)
      cnt <= cnt - 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      res0  <= '0;
      res1  <= '0;
      op_r  <= OP_KEYGEN;
      phase <= 1'b0;
      q_r   <= '0;
      k_r   <= '0;
      y_r   <= '0;
      m_r   <= '0;
      c2_r  <= '0;
      acc   <= '0;
      base  <= '0;
      shreg <= '0;
      hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= op;
            q_r   <= q;
            k_r   <= eph_k;
            y_r   <= pub_y;
            m_r   <= msg;
            c2_r  <= c2_in;
            phase <= 1'b0;
            ready <= 1'b0;
            busy  <= 1'b1;
            acc   <= W'(1);
            base  <= init_base;
            shreg <= (op == OP_ENCRYPT) ? eph_k : priv_a;
            if (illegal) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= EXP;
            end
          end
        end
        EXP: begin
          acc   <= step_acc;
          base  <= mod_bb;
          shreg <= shreg >> 1;
          if (exp_last) begin
            // Next phase is loaded here so phases run back to back.
            case ({op_r, phase})
              {OP_ENCRYPT, 1'b0}: begin
                hold  <= step_acc;
                acc   <= W'(1);
                base  <= y_r % q_r;
                shreg <= k_r;
                phase <= 1'b1;
              end
              {OP_ENCRYPT, 1'b1}: begin
                acc   <= step_acc;
                base  <= m_r;
                state <= MUL;
              end
              {OP_DECRYPT, 1'b0}: begin
                if (step_acc == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
                  err   <= 1'b1;
                end else begin
                  hold  <= step_acc;
                  acc   <= W'(1);
                  base  <= step_acc;
                  shreg <= q_r - W'(2);
                  phase <= 1'b1;
                end
              end
              {OP_DECRYPT, 1'b1}: begin
                acc   <= c2_r;
                base  <= step_acc;
                state <= MUL;
              end
              default: begin
                res0  <= step_acc;
                done  <= 1'b1;
                err   <= 1'b0;
                state <= DONE;
              end
            endcase
          end
        end
        MUL: begin
          done  <= 1'b1;
          err   <= 1'b0;
          state <= DONE;
          if (op_r == OP_ENCRYPT) begin
            res0 <= hold;
            res1 <= mod_ab;
          end else begin
            res0 <= mod_ab;
            res1 <= hold;
          end
        end
        DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_elgamal_sequencer.sv
// Directed self-checking bench for elgamal_sequencer (W=32), latencies follow the build macro.
module tb_elgamal_sequencer;
  localparam int W = 32;
`ifdef ELGAMAL_SEQ_EARLY_EXIT_EN
  localparam int KG_LAT  = 4;
  localparam int ENC_LAT = 8;
  localparam int DEC_LAT = 8;
  localparam int S0_LAT  = 4;
  localparam int KG0_LAT = 2;
  localparam int RST_AT  = 4;
`else
  localparam int KG_LAT  = 33;
  localparam int ENC_LAT = 66;
  localparam int DEC_LAT = 66;
  localparam int S0_LAT  = 33;
  localparam int KG0_LAT = 33;
  localparam int RST_AT  = W + 4;
`endif
  localparam int ERR_LAT = 1;

  logic clk = 1'b0;
  logic rst, start;
  logic [1:0] op;
  logic [W-1:0] g, q, priv_a, eph_k, pub_y, msg, c1_in, c2_in;
  logic ready, busy, done, err;
  logic [W-1:0] res0, res1;

  int vectors = 0;
  int miscompares = 0;
  int lat;

  always #5 clk = ~clk;

  elgamal_sequencer #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .g(g), .q(q), .priv_a(priv_a), .eph_k(eph_k), .pub_y(pub_y), .msg(msg),
    .c1_in(c1_in), .c2_in(c2_in),
    .ready(ready), .busy(busy), .done(done), .err(err), .res0(res0), .res1(res1)
  );

  // Accept happens on the next edge; inputs are scrambled afterwards to prove they were latched.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] gg, qq, aa, kk, yy, mm, cc1, cc2);
    op = o; g = gg; q = qq; priv_a = aa; eph_k = kk; pub_y = yy; msg = mm; c1_in = cc1; c2_in = cc2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'd3; g = '1; q = 32'd0; priv_a = '1; eph_k = '1; pub_y = '1; msg = '1; c1_in = '1; c2_in = '1;
  endtask

  // lat counts cycles from the accept cycle T; poke_at > 0 pulses a stray start at that count.
  task automatic wait_done(input int poke_at, output int l);
    l = 1;
    while (!done && l < 300) begin
      if (l == poke_at) begin
        start = 1'b1; op = 2'd0; g = 32'd2; q = 32'd11; priv_a = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      l++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
    vectors++; if (res0 !== 32'd0) begin miscompares++; $display("FAIL reset_res0 got %0d want 0", res0); end
    vectors++; if (res1 !== 32'd0) begin miscompares++; $display("FAIL reset_res1 got %0d want 0", res1); end
  endtask

  task automatic test_keygen();
    launch(2'd0, 32'd3, 32'd7, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    vectors++; if (busy !== 1'b1 || ready !== 1'b0) begin miscompares++; $display("FAIL kg_busy got busy=%b ready=%b want 1/0", busy, ready); end
    wait_done(0, lat);
    vectors++; if (lat !== KG_LAT) begin miscompares++; $display("FAIL kg_latency got %0d want %0d", lat, KG_LAT); end
    vectors++; if (res0 !== 32'd5) begin miscompares++; $display("FAIL kg_res0 got %0d want 5", res0); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL kg_err got %b want 0", err); end
    @(posedge clk); #1;
    vectors++; if (ready !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL kg_idle got ready=%b done=%b want 1/0", ready, done); end
  endtask

  task automatic test_encrypt();
    launch(2'd1, 32'd3, 32'd7, 32'd0, 32'd4, 32'd5, 32'd6, 32'd0, 32'd0);
    wait_done(0, lat);
    vectors++; if (lat !== ENC_LAT) begin miscompares++; $display("FAIL enc_latency got %0d want %0d", lat, ENC_LAT); end
    vectors++; if (res0 !== 32'd4) begin miscompares++; $display("FAIL enc_c1 got %0d want 4", res0); end
    vectors++; if (res1 !== 32'd5) begin miscompares++; $display("FAIL enc_c2 got %0d want 5", res1); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL enc_err got %b want 0", err); end
    @(posedge clk); #1;
  endtask

  task automatic test_decrypt();
    launch(2'd2, 32'd0, 32'd7, 32'd5, 32'd0, 32'd0, 32'd0, 32'd4, 32'd5);
    wait_done(2, lat);
    vectors++; if (lat !== DEC_LAT) begin miscompares++; $display("FAIL dec_latency got %0d want %0d", lat, DEC_LAT); end
    vectors++; if (res0 !== 32'd6) begin miscompares++; $display("FAIL dec_m got %0d want 6", res0); end
    vectors++; if (res1 !== 32'd2) begin miscompares++; $display("FAIL dec_s got %0d want 2", res1); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL dec_err got %b want 0", err); end
    @(posedge clk); #1;
  endtask

  task automatic test_errors();
    launch(2'd3, 32'd3, 32'd7, 32'd5, 32'd4, 32'd5, 32'd6, 32'd4, 32'd5);
    wait_done(0, lat);
    vectors++; if (lat !== ERR_LAT) begin miscompares++; $display("FAIL op3_latency got %0d want %0d", lat, ERR_LAT); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL op3_err got %b want 1", err); end
    vectors++; if (res0 !== 32'd6 || res1 !== 32'd2) begin miscompares++; $display("FAIL op3_res got %0d/%0d want 6/2", res0, res1); end
    @(posedge clk); #1;
    launch(2'd0, 32'd3, 32'd1, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    wait_done(0, lat);
    vectors++; if (lat !== ERR_LAT) begin miscompares++; $display("FAIL q1_latency got %0d want %0d", lat, ERR_LAT); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL q1_err got %b want 1", err); end
    vectors++; if (res0 !== 32'd6 || res1 !== 32'd2) begin miscompares++; $display("FAIL q1_res got %0d/%0d want 6/2", res0, res1); end
    @(posedge clk); #1;
    launch(2'd2, 32'd0, 32'd7, 32'd5, 32'd0, 32'd0, 32'd0, 32'd14, 32'd5);
    wait_done(0, lat);
    vectors++; if (lat !== S0_LAT) begin miscompares++; $display("FAIL s0_latency got %0d want %0d", lat, S0_LAT); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL s0_err got %b want 1", err); end
    vectors++; if (res0 !== 32'd6 || res1 !== 32'd2) begin miscompares++; $display("FAIL s0_res got %0d/%0d want 6/2", res0, res1); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    launch(2'd0, 32'd3, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    wait_done(0, lat);
    vectors++; if (lat !== KG0_LAT) begin miscompares++; $display("FAIL kg0_latency got %0d want %0d", lat, KG0_LAT); end
    vectors++; if (res0 !== 32'd1) begin miscompares++; $display("FAIL kg0_res0 got %0d want 1", res0); end
    @(posedge clk); #1;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready got %b want 1", ready); end
    launch(2'd0, 32'd3, 32'd7, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
    wait_done(0, lat);
    vectors++; if (lat !== KG_LAT) begin miscompares++; $display("FAIL b2b_latency got %0d want %0d", lat, KG_LAT); end
    vectors++; if (res0 !== 32'd5) begin miscompares++; $display("FAIL b2b_res0 got %0d want 5", res0); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    bit saw_done;
    launch(2'd1, 32'd3, 32'd7, 32'd0, 32'd4, 32'd5, 32'd6, 32'd0, 32'd0);
    repeat (RST_AT - 1) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL mid_busy got busy=%b done=%b want 1/0", busy, done); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
      begin miscompares++; $display("FAIL mid_rst_flags got r=%b b=%b d=%b e=%b want 1/0/0/0", ready, busy, done, err); end
    vectors++; if (res0 !== 32'd0 || res1 !== 32'd0) begin miscompares++; $display("FAIL mid_rst_res got %0d/%0d want 0/0", res0, res1); end
    saw_done = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("FAIL mid_no_done got %b want 0", saw_done); end
    launch(2'd0, 32'd2, 32'd11, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    wait_done(0, lat);
    vectors++; if (lat !== KG_LAT) begin miscompares++; $display("FAIL post_rst_latency got %0d want %0d", lat, KG_LAT); end
    vectors++; if (res0 !== 32'd7) begin miscompares++; $display("FAIL post_rst_res0 got %0d want 7", res0); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'd0;
    g = '0; q = '0; priv_a = '0; eph_k = '0; pub_y = '0; msg = '0; c1_in = '0; c2_in = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_keygen();
    test_encrypt();
    test_decrypt();
    test_errors();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
